// File: rtl/wfm_pkg.sv
// ---------------------------------------------------------------------------
// wfm_pkg
// Shared types and constants for the wave_freq_meter slice.
//   wfm_state_t : measurement FSM states (IDLE, ARM, MEAS, DONE)
//   mid_of()    : midscale code of an offset-binary sample of width w
//   DEF_*       : default parameter values used by the modules
// ---------------------------------------------------------------------------
package wfm_pkg;

    localparam int unsigned DEF_DATA_W      = 14;
    localparam int unsigned DEF_CNT_W       = 32;
    localparam int unsigned DEF_HYST        = 256;
    localparam int unsigned DEF_TIMEOUT_CYC = 2**24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2,
        DONE = 2'd3
    } wfm_state_t;

    // Offset binary: midscale is the MSB alone.
    function automatic int unsigned mid_of(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/wfm_cross_det.sv
// ---------------------------------------------------------------------------
// wfm_cross_det
// Rising midscale crossing detector with hysteresis.
//   Clk, Reset_n  : clock, asynchronous active-low reset
//   Sample_Valid  : sample qualifier
//   Sample        : offset-binary sample
//   Rise          : registered one-cycle pulse, one Clk after the valid sample
//                   that reached MID+HYST while armed
// A valid sample below MID-HYST arms the detector; samples inside the band
// change nothing, so noise around midscale cannot produce a second pulse.
// ---------------------------------------------------------------------------
module wfm_cross_det
    import wfm_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned HYST   = DEF_HYST
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Sample_Valid,
    input  logic [DATA_W-1:0] Sample,
    output logic              Rise
);

    localparam int unsigned       MID   = mid_of(DATA_W);
    localparam logic [DATA_W-1:0] LO_TH = DATA_W'(MID - HYST);
    localparam logic [DATA_W-1:0] HI_TH = DATA_W'(MID + HYST);

    logic armed;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            armed <= 1'b0;
            Rise  <= 1'b0;
        end else begin
            Rise <= 1'b0;
            if (Sample_Valid) begin
                if (Sample < LO_TH) begin
                    armed <= 1'b1;
                end else if (Sample >= HI_TH && armed) begin
                    Rise  <= 1'b1;
                    armed <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/wave_freq_meter.sv
// ---------------------------------------------------------------------------
// wave_freq_meter
// Measures the Clk-cycle length of N whole periods of a sampled waveform.
//   Clk, Reset_n  : clock, asynchronous active-low reset
//   Sample_Valid  : sample qualifier
//   Sample        : offset-binary sample (DATA_W bits)
//   Start         : one-cycle pulse, accepted only in IDLE
//   Periods       : number of periods N, latched on Start (0 means 1)
//   Busy          : high while armed or measuring
//   Done          : one-cycle result pulse
//   Timeout       : sticky until next Start, set when a measurement aborts
//   Cycle_Cnt     : cycles spanning N periods (0 on timeout), held to next Done
//   Vpp           : peak-to-peak over the measurement
// Optional feature macro: WFM_AMP_MEAS_EN enables the min/max tracker behind
// Vpp; without it Vpp is constant 0.
// ---------------------------------------------------------------------------
module wave_freq_meter
    import wfm_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned HYST        = DEF_HYST,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Sample_Valid,
    input  logic [DATA_W-1:0] Sample,
    input  logic              Start,
    input  logic [7:0]        Periods,
    output logic              Busy,
    output logic              Done,
    output logic              Timeout,
    output logic [CNT_W-1:0]  Cycle_Cnt,
    output logic [DATA_W-1:0] Vpp
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

    wfm_state_t       state, state_nxt;
    logic             rise;
    logic [7:0]       per_tgt;
    logic [7:0]       per_cnt;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] acc_inc;
    logic [WD_W-1:0]  wd;
    logic             wd_expire;
    logic             last_rise;

    wfm_cross_det #(
        .DATA_W (DATA_W),
        .HYST   (HYST)
    ) u_cross (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Sample_Valid (Sample_Valid),
        .Sample       (Sample),
        .Rise         (rise)
    );

    // Saturating accumulator increment.
    assign acc_inc = (&acc) ? acc : acc + CNT_W'(1);

    always_comb begin
        state_nxt = state;
        Busy      = 1'b0;
        Done      = 1'b0;
        // A rise in the expiry cycle clears the watchdog instead.
        wd_expire = (wd == WD_W'(TIMEOUT_CYC - 1)) && !rise;
        last_rise = rise && ((per_cnt + 8'd1) == per_tgt);
        case (state)
            IDLE: begin
                if (Start) state_nxt = ARM;
            end
            ARM: begin
                Busy = 1'b1;
                if (rise)           state_nxt = MEAS;
                else if (wd_expire) state_nxt = DONE;
            end
            MEAS: begin
                Busy = 1'b1;
                if (last_rise || wd_expire) state_nxt = DONE;
            end
            DONE: begin
                Done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            per_tgt   <= 8'd1;
            per_cnt   <= '0;
            acc       <= '0;
            wd        <= '0;
            Timeout   <= 1'b0;
            Cycle_Cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (Start) begin
                        per_tgt <= (Periods == 8'd0) ? 8'd1 : Periods;
                        Timeout <= 1'b0;
                        wd      <= '0;
                    end
                end
                ARM: begin
                    if (rise) begin
                        acc     <= '0;
                        per_cnt <= '0;
                        wd      <= '0;
                    end else if (wd_expire) begin
                        Timeout   <= 1'b1;
                        Cycle_Cnt <= '0;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                MEAS: begin
                    acc <= acc_inc;
                    if (rise) begin
                        per_cnt <= per_cnt + 8'd1;
                        wd      <= '0;
                        // Result includes the cycle carrying the final rise.
                        if (last_rise) Cycle_Cnt <= acc_inc;
                    end else if (wd_expire) begin
                        Timeout   <= 1'b1;
                        Cycle_Cnt <= '0;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef WFM_AMP_MEAS_EN
    logic [DATA_W-1:0] amp_min, amp_max, vpp_r;
    logic [DATA_W-1:0] s_min, s_max;

    // Running extremes including the current sample, so the final-rise
    // cycle contributes to the loaded result.
    always_comb begin
        s_min = amp_min;
        s_max = amp_max;
        if (Sample_Valid) begin
            if (Sample < amp_min) s_min = Sample;
            if (Sample > amp_max) s_max = Sample;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            amp_min <= '1;
            amp_max <= '0;
            vpp_r   <= '0;
        end else begin
            case (state)
                ARM: begin
                    if (rise) begin
                        amp_min <= Sample_Valid ? Sample : '1;
                        amp_max <= Sample_Valid ? Sample : '0;
                    end else if (wd_expire) begin
                        vpp_r <= '0;
                    end
                end
                MEAS: begin
                    if (last_rise) begin
                        vpp_r <= (s_max >= s_min) ? (s_max - s_min) : '0;
                    end else if (wd_expire) begin
                        vpp_r <= '0;
                    end else begin
                        amp_min <= s_min;
                        amp_max <= s_max;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Vpp = vpp_r;
`else
    assign Vpp = '0;
`endif

endmodule

// File: tb/tb_wave_freq_meter.sv
// ---------------------------------------------------------------------------
// tb_wave_freq_meter
// Directed stimulus with a cycle-level expectation model for wave_freq_meter.
// The model derives results from rise-event times: Cycle_Cnt is the distance
// in cycles between the first and the N-th following rise, and a timeout is a
// deadline TIMEOUT cycles after the last watchdog clear.
// ---------------------------------------------------------------------------
module tb_wave_freq_meter;

    localparam int TO     = 3000;
    localparam int LO_TH  = 8192 - 256;
    localparam int HI_TH  = 8192 + 256;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Sample_Valid;
    logic [13:0] Sample = 14'd8192;
    logic        Start;
    logic [7:0]  Periods;
    logic        Busy, Done, Timeout;
    logic [31:0] Cycle_Cnt;
    logic [13:0] Vpp;

    wave_freq_meter #(
        .DATA_W      (14),
        .CNT_W       (32),
        .HYST        (256),
        .TIMEOUT_CYC (TO)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Sample_Valid (Sample_Valid),
        .Sample       (Sample),
        .Start        (Start),
        .Periods      (Periods),
        .Busy         (Busy),
        .Done         (Done),
        .Timeout      (Timeout),
        .Cycle_Cnt    (Cycle_Cnt),
        .Vpp          (Vpp)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc++;

    // ---------------- waveform source ----------------
    int w_mode  = 0;   // 0: constant midscale, 1: sine
    int w_per   = 1000;
    int w_lo    = 0;
    int w_hi    = 16383;
    int w_noise = 0;
    int wt      = 0;

    function automatic logic [13:0] wave_at(input int t);
        real c, a, v;
        int  ph, iv;
        ph = t % w_per;
        c  = (w_lo + w_hi) / 2.0;
        a  = (w_hi - w_lo) / 2.0;
        v  = c + a * $sin(6.283185307179586 * ph / w_per);
        if (w_noise != 0 && v > 7892.0 && v < 8492.0)
            v = v + (((ph % 2) == 1) ? 100.0 : -100.0);
        iv = $rtoi(v + 0.5);
        if (iv < 0) iv = 0;
        if (iv > 16383) iv = 16383;
        return iv[13:0];
    endfunction

    always @(posedge Clk) begin
        #1;
        wt++;
        Sample = (w_mode == 0) ? 14'd8192 : wave_at(wt);
    end

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Literal expectations posted by the directed sequence for the next Done.
    int lit_seq = 0, lit_used = 0;
    int lit_cnt, lit_to, lit_lat, lit_vpp, lit_start;
    int done_cnt = 0;
    int hang_cnt = 0, hang_seen = 0;

    // ---------------- model state ----------------
    int ph = 0;            // 0 idle, 1 waiting for first rise, 2 measuring, 3 result cycle
    int n_tgt, nr, r0, deadline;
    int m_cnt = 0, m_to = 0, m_vpp = 0;
    int mn, mx;
    bit m_armed = 0, mr_cur = 0, rise_c;

    function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction
    function automatic int imax(input int a, input int b); return (a > b) ? a : b; endfunction

    always @(negedge Clk) begin
        if (hang_cnt != hang_seen) begin
            hang_seen = hang_cnt;
            chk("done_wait_expired", 32'd0, 32'd1);
        end
        if (!Reset_n) begin
            chk("rst_busy",    32'(Busy),    32'd0);
            chk("rst_done",    32'(Done),    32'd0);
            chk("rst_timeout", 32'(Timeout), 32'd0);
            chk("rst_cnt",     Cycle_Cnt,    32'd0);
            chk("rst_vpp",     32'(Vpp),     32'd0);
            ph = 0; m_cnt = 0; m_to = 0; m_vpp = 0; m_armed = 0; mr_cur = 0;
        end else begin
            chk("busy",    32'(Busy),    32'((ph == 1) || (ph == 2)));
            chk("done",    32'(Done),    32'(ph == 3));
            chk("timeout", 32'(Timeout), 32'(m_to));
            chk("cnt",     Cycle_Cnt,    32'(m_cnt));
            chk("vpp",     32'(Vpp),     32'(m_vpp));
            if (Done === 1'b1) begin
                done_cnt++;
                if (lit_seq != lit_used) begin
                    lit_used = lit_seq;
                    chk("lit_cnt",     Cycle_Cnt,    32'(lit_cnt));
                    chk("lit_timeout", 32'(Timeout), 32'(lit_to));
                    if (lit_lat >= 0) chk("lit_latency", 32'(cyc - lit_start), 32'(lit_lat));
                    if (lit_vpp >= 0) chk("lit_vpp", 32'(Vpp), 32'(lit_vpp));
                end
            end

            // rise event belonging to this cycle, and the one for the next
            rise_c = mr_cur;
            mr_cur = 0;
            if (Sample_Valid) begin
                if (int'(Sample) < LO_TH) m_armed = 1;
                else if (int'(Sample) >= HI_TH && m_armed) begin
                    mr_cur  = 1;
                    m_armed = 0;
                end
            end

            case (ph)
                0: if (Start) begin
                    ph       = 1;
                    n_tgt    = (Periods == 8'd0) ? 1 : int'(Periods);
                    m_to     = 0;
                    deadline = cyc + 1 + TO;
                end
                1: if (rise_c) begin
                    ph       = 2;
                    r0       = cyc;
                    nr       = 0;
                    deadline = cyc + 1 + TO;
                    mn       = Sample_Valid ? int'(Sample) : 16383;
                    mx       = Sample_Valid ? int'(Sample) : 0;
                end else if (cyc + 1 == deadline) begin
                    ph = 3; m_to = 1; m_cnt = 0; m_vpp = 0;
                end
                2: begin
                    if (Sample_Valid) begin
                        mn = imin(mn, int'(Sample));
                        mx = imax(mx, int'(Sample));
                    end
                    if (rise_c) begin
                        nr++;
                        deadline = cyc + 1 + TO;
                        if (nr == n_tgt) begin
                            ph    = 3;
                            m_cnt = cyc - r0;
`ifdef WFM_AMP_MEAS_EN
                            m_vpp = (mx >= mn) ? mx - mn : 0;
`endif
                        end
                    end else if (cyc + 1 == deadline) begin
                        ph = 3; m_to = 1; m_cnt = 0; m_vpp = 0;
                    end
                end
                default: ph = 0;
            endcase
        end
    end

    // ---------------- directed sequence ----------------
    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic set_wave(input int per, input int lo, input int hi, input int noise);
        w_per = per; w_lo = lo; w_hi = hi; w_noise = noise; w_mode = 1;
    endtask

    task automatic expect_lit(input int cnt, input int to, input int lat, input int vpp);
        lit_cnt = cnt; lit_to = to; lit_lat = lat; lit_vpp = vpp;
        lit_seq++;
    endtask

    task automatic do_start(input int p);
        Periods   = 8'(p);
        Start     = 1'b1;
        lit_start = cyc;
        tick();
        Start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int base, n;
        base = done_cnt;
        n    = 0;
        while (done_cnt == base && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt == base) hang_cnt++;
        tick();
    endtask

    initial begin
        Reset_n      = 1'b0;
        Start        = 1'b0;
        Periods      = 8'd0;
        Sample_Valid = 1'b1;
        repeat (3) tick();
        Reset_n = 1'b1;
        repeat (3) tick();

        // clean sine, 4 periods of 1000
        set_wave(1000, 1000, 15383, 0);
        repeat (50) tick();
        expect_lit(4000, 0, -1, -1);
        do_start(4);
        wait_done(6000);

        // noisy sine near midscale, 2 periods of 500
        set_wave(500, 1000, 15383, 1);
        repeat (600) tick();
        expect_lit(1000, 0, -1, -1);
        do_start(2);
        wait_done(3000);

        // Periods=0 measures one period; a Start while busy is ignored
        set_wave(700, 1000, 15383, 0);
        repeat (100) tick();
        expect_lit(700, 0, -1, -1);
        do_start(0);
        repeat (100) tick();
        Periods = 8'd9;
        Start   = 1'b1;
        tick();
        Start   = 1'b0;
        wait_done(3000);
        repeat (1500) tick();

        // reset in the middle of a measurement
        set_wave(1000, 1000, 15383, 0);
        repeat (50) tick();
        do_start(4);
        repeat (1500) tick();
        Reset_n = 1'b0;
        repeat (3) tick();
        Reset_n = 1'b1;
        repeat (5) tick();

        // next measurement after reset
        set_wave(800, 1000, 15383, 0);
        repeat (100) tick();
        expect_lit(2400, 0, -1, -1);
        do_start(3);
        wait_done(5000);

        // constant midscale: watchdog expiry
        w_mode = 0;
        repeat (20) tick();
        expect_lit(0, 1, TO + 1, 0);
        do_start(4);
        wait_done(TO + 100);
        repeat (20) tick();

        // amplitude: full scale then half amplitude
        set_wave(1000, 0, 16383, 0);
        repeat (50) tick();
`ifdef WFM_AMP_MEAS_EN
        expect_lit(1000, 0, -1, 16383);
`else
        expect_lit(1000, 0, -1, 0);
`endif
        do_start(1);
        wait_done(3000);

        set_wave(1000, 4096, 12287, 0);
        repeat (50) tick();
`ifdef WFM_AMP_MEAS_EN
        expect_lit(1000, 0, -1, 8191);
`else
        expect_lit(1000, 0, -1, 0);
`endif
        do_start(1);
        wait_done(3000);

        repeat (5) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
